// File: rtl/occupancy_ctrl_pkg.sv
// occupancy_ctrl shared definitions
// state encodings, LED colours, colour lookup
package occupancy_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_FREE     = 2'd1,
    ST_OCCUPIED = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  localparam logic [2:0] COLOR_WARMUP = 3'b001;
  localparam logic [2:0] COLOR_FREE   = 3'b010;
  localparam logic [2:0] COLOR_OCC    = 3'b100;
  localparam logic [2:0] COLOR_HOLD   = 3'b110;

  function automatic logic [2:0] color_of(
    input state_e s
  );
    logic [2:0] c;
    c = COLOR_WARMUP;
    unique case (s)
      ST_WARMUP:   c = COLOR_WARMUP;
      ST_FREE:     c = COLOR_FREE;
      ST_OCCUPIED: c = COLOR_OCC;
      ST_HOLD:     c = COLOR_HOLD;
      default:     c = COLOR_WARMUP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/occupancy_ctrl_pir_debounce.sv
// pir_debounce: 2-flop synchronizer plus level qualifier
// a new level must persist DEBOUNCE_CYCLES samples
module pir_debounce
  import occupancy_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic pir_in,
  output logic pir_stable
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // qualify: accept a differing level after DB_LAST+1 samples
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // synchronizer and debounce state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pir_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pir_stable = stable_q;

endmodule

// File: rtl/occupancy_ctrl.sv
// occupancy_ctrl: warm-up, occupancy FSM, hold timer,
// event pulses and saturating count, all registered
module occupancy_ctrl
  import occupancy_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int HOLD_CYCLES     = 5000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pir_in,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             occupied,
  output logic             occ_event,
  output logic             free_event,
  output logic [CNT_W-1:0] occ_count
);

  localparam int TMAX =
    (WARMUP_CYCLES > HOLD_CYCLES) ? WARMUP_CYCLES
                                  : HOLD_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [TMR_W-1:0] WU_LAST =
    TMR_W'(WARMUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HD_LAST =
    TMR_W'(HOLD_CYCLES - 1);

  logic pir_stable;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       led_q, led_d;
  logic             occ_q, occ_d;
  logic             oev_q, oev_d;
  logic             fev_q, fev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  pir_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk       (clk),
    .rst       (rst),
    .pir_in    (pir_in),
    .pir_stable(pir_stable)
  );

  // next state, timer, events; outputs follow next state
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    oev_d   = 1'b0;
    fev_d   = 1'b0;
    unique case (state_q)
      ST_WARMUP: begin
        if (tmr_q == WU_LAST) begin
          tmr_d = '0;
          if (pir_stable) begin
            state_d = ST_OCCUPIED;
            oev_d   = 1'b1;
          end else begin
            state_d = ST_FREE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_FREE: begin
        if (pir_stable) begin
          state_d = ST_OCCUPIED;
          oev_d   = 1'b1;
        end
      end
      ST_OCCUPIED: begin
        if (!pir_stable) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_HOLD: begin
        if (pir_stable) begin
          state_d = ST_OCCUPIED;
        end else if (tmr_q == HD_LAST) begin
          state_d = ST_FREE;
          fev_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WARMUP;
        tmr_d   = '0;
      end
    endcase
    cnt_d = cnt_q;
    if (oev_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    led_d = color_of(state_d);
    occ_d = (state_d == ST_OCCUPIED) ||
            (state_d == ST_HOLD);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      tmr_q   <= '0;
      led_q   <= COLOR_WARMUP;
      occ_q   <= 1'b0;
      oev_q   <= 1'b0;
      fev_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
      occ_q   <= occ_d;
      oev_q   <= oev_d;
      fev_q   <= fev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {led_r, led_g, led_b} = led_q;
  assign occupied   = occ_q;
  assign occ_event  = oev_q;
  assign free_event = fev_q;
  assign occ_count  = cnt_q;

endmodule

// File: tb/tb_occupancy_ctrl.sv
// tb_occupancy_ctrl: scoreboard bench, two DUTs
// (CNT_W=16 and CNT_W=2) driven by the same stimulus
module tb_occupancy_ctrl;

  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic       occ;
    logic       oev;
    logic       fev;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pir_in;

  logic a_r, a_g, a_b, a_occ, a_oev, a_fev;
  logic [15:0] a_cnt;
  logic b_r, b_g, b_b, b_occ, b_oev, b_fev;
  logic [1:0] b_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [2:0] prev_led = 3'b001;

  exp_t q1[$];
  exp_t q2[$];

  occupancy_ctrl #(
    .WARMUP_CYCLES(10), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .pir_in(pir_in),
    .led_r(a_r), .led_g(a_g), .led_b(a_b),
    .occupied(a_occ), .occ_event(a_oev),
    .free_event(a_fev), .occ_count(a_cnt)
  );

  occupancy_ctrl #(
    .WARMUP_CYCLES(10), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .pir_in(pir_in),
    .led_r(b_r), .led_g(b_g), .led_b(b_b),
    .occupied(b_occ), .occ_event(b_oev),
    .free_event(b_fev), .occ_count(b_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp_v);
    end
  endtask

  task automatic expect1(input int dc,
                         input logic [2:0] led,
                         input logic oev, input logic fev,
                         input logic [15:0] cnt);
    exp_t e;
    e.cyc = cyc + dc;
    e.led = led;
    e.occ = (led == 3'b100) || (led == 3'b110);
    e.oev = oev;
    e.fev = fev;
    e.cnt = cnt;
    q1.push_back(e);
  endtask

  task automatic expect2(input int dc,
                         input logic [15:0] cnt);
    exp_t e;
    e.cyc = cyc + dc;
    e.led = 3'b100;
    e.occ = 1'b1;
    e.oev = 1'b1;
    e.fev = 1'b0;
    e.cnt = cnt;
    q2.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor A: any LED change or event pulse is a transaction
  always @(negedge clk) begin
    logic [2:0] led;
    exp_t e;
    led = {a_r, a_g, a_b};
    if (mon_en && (led != prev_led || a_oev || a_fev)) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_a: cyc %0d led %b ev %b%b",
                 cyc, led, a_oev, a_fev);
      end else begin
        e = q1.pop_front();
        if (cyc != e.cyc || led != e.led ||
            a_occ != e.occ || a_oev != e.oev ||
            a_fev != e.fev || a_cnt != e.cnt) begin
          failures++;
          $display({"FAIL trans_a: got cyc %0d led %b occ %b ",
                    "oev %b fev %b cnt %0d want cyc %0d led %b ",
                    "occ %b oev %b fev %b cnt %0d"},
                   cyc, led, a_occ, a_oev, a_fev, a_cnt,
                   e.cyc, e.led, e.occ, e.oev, e.fev, e.cnt);
        end
      end
    end
    prev_led = led;
  end

  // monitor B: each occ_event pulse of the narrow-counter DUT
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && b_oev) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL unexpected_b: cyc %0d cnt %0d",
                 cyc, b_cnt);
      end else begin
        e = q2.pop_front();
        if (cyc != e.cyc || {14'b0, b_cnt} != e.cnt) begin
          failures++;
          $display("FAIL sat_b: got cyc %0d cnt %0d want cyc %0d cnt %0d",
                   cyc, b_cnt, e.cyc, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    pir_in = 1'b1;
    @(negedge clk);
    chk("rst_led", {13'b0, a_r, a_g, a_b}, 16'h1);
    chk("rst_occ", {15'b0, a_occ}, 16'h0);
    chk("rst_ev", {14'b0, a_oev, a_fev}, 16'h0);
    chk("rst_cnt", a_cnt, 16'h0);
    chk("rst_cnt_b", {14'b0, b_cnt}, 16'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    // warm-up with motion present from reset
    expect1(10, 3'b100, 1'b1, 1'b0, 16'd1);
    expect2(10, 16'd1);
    wait_cyc(14);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd1);
    expect1(27, 3'b010, 1'b0, 1'b1, 16'd1);
    wait_cyc(35);
    // 3-cycle glitch in FREE is rejected
    pir_in = 1'b1;
    wait_cyc(3);
    pir_in = 1'b0;
    wait_cyc(15);
    chk("glitch_led", {13'b0, a_r, a_g, a_b}, 16'h2);
    chk("glitch_cnt", a_cnt, 16'd1);
    chk("glitch_occ", {15'b0, a_occ}, 16'h0);
    // full episode
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b1, 1'b0, 16'd2);
    expect2(7, 16'd2);
    wait_cyc(30);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd2);
    expect1(27, 3'b010, 1'b0, 1'b1, 16'd2);
    wait_cyc(35);
    // retrigger at HOLD cycle 10, timer restarts
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b1, 1'b0, 16'd3);
    expect2(7, 16'd3);
    wait_cyc(15);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd3);
    wait_cyc(17);
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b0, 1'b0, 16'd3);
    wait_cyc(13);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd3);
    expect1(27, 3'b010, 1'b0, 1'b1, 16'd3);
    wait_cyc(35);
    // retrigger lands on the expiry cycle: retrigger wins
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b1, 1'b0, 16'd4);
    expect2(7, 16'd3);
    wait_cyc(15);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd4);
    wait_cyc(20);
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b0, 1'b0, 16'd4);
    wait_cyc(15);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd4);
    expect1(27, 3'b010, 1'b0, 1'b1, 16'd4);
    wait_cyc(35);
    // reset in the middle of HOLD
    pir_in = 1'b1;
    expect1(7, 3'b100, 1'b1, 1'b0, 16'd5);
    expect2(7, 16'd3);
    wait_cyc(15);
    pir_in = 1'b0;
    expect1(7, 3'b110, 1'b0, 1'b0, 16'd5);
    wait_cyc(12);
    rst = 1'b1;
    expect1(1, 3'b001, 1'b0, 1'b0, 16'd0);
    wait_cyc(1);
    chk("mid_rst_occ", {15'b0, a_occ}, 16'h0);
    chk("mid_rst_cnt", a_cnt, 16'h0);
    chk("mid_rst_cnt_b", {14'b0, b_cnt}, 16'h0);
    rst = 1'b0;
    expect1(10, 3'b010, 1'b0, 1'b0, 16'd0);
    wait_cyc(20);
    chk("left_a", 16'(q1.size()), 16'h0);
    chk("left_b", 16'(q2.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
